candy_dispenser: RTL and testbench
==================================

# candy_dispenser

Actuator-side controller for the candy vending machine: consumes the `candy` and `money_ret` level outputs of the vending FSM and turns them into timed solenoid pulses. It drives the candy-release motor and the coin-return gate and tracks remaining stock. It also refunds instead of vending when stock is exhausted, and reports busy/done status back toward the FSM.

## Interface
- `PULSE_CYCLES`, default 4: actuator on-time in clock cycles; legal range ≥1.
- `INV_WIDTH`, default 4: width of the stock counter.
- `INV_INIT`, default 10: stock value loaded at reset and on refill; must be ≤ 2^INV_WIDTH−1.

Ports, clock and reset first:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `candy` in 1: vend request level from the vending FSM.
- `money_ret` in 1: coin-return request level from the vending FSM.
- `refill` in 1: synchronous load of stock to `INV_INIT`.
- `vend_motor` out 1: candy-release solenoid, registered.
- `coin_gate` out 1: coin-return solenoid, registered.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse when a transaction completes.
- `empty` out 1: `stock == 0`.
- `fault` out 1: sticky flag, set on a vend attempted while empty; cleared by refill.
- `stock` out `INV_WIDTH`: current inventory.

## Operation
- Rising-edge detection on `candy` and `money_ret` uses registered previous values (`prev` regs, updated every cycle). A rise is an input that is 1 now and was 0 in the previous cycle.
- States:
  - **IDLE**: `busy`=0. On any rise, latch `pend_candy` and `pend_coin`, then go to VEND if `pend_candy` else COIN.
  - **VEND**: `vend_motor`=1 for `PULSE_CYCLES` cycles. On the last VEND cycle, `stock` decrements. Next state is COIN if `pend_coin` else DONE.
  - **COIN**: `coin_gate`=1 for `PULSE_CYCLES` cycles, then DONE.
  - **DONE**: `done`=1 for one cycle, then IDLE.
- Simultaneous rises on both inputs (FSM state 11, candy + change): vend first, then coin, as one transaction with a single `done`.
- Empty stock at capture: a candy rise with `stock==0` skips VEND, forces `pend_coin`=1 (refund) and sets `fault`. If both inputs rise while empty, there is exactly one coin pulse.
- Rises occurring while `busy`=1 are dropped; no queueing. The `prev` regs still track, so a level held through the end of the transaction does not retrigger.
- `refill` is honoured in any state. If it coincides with the decrement cycle, the load of `INV_INIT` wins. Refill clears `fault`.
- Stock never wraps: a decrement occurs only when stock ≥1, which is guaranteed by the capture check.

## Timing
- Reset values: state IDLE, `vend_motor`=0, `coin_gate`=0, `busy`=0, `done`=0, `fault`=0, `stock`=`INV_INIT`, `empty`=(`INV_INIT`==0), `prev` regs=0, pulse counter=0.
- Reset asserted mid-transaction: actuators drop immediately (asynchronously), no `done` is produced, and stock is restored to `INV_INIT`.
- Rise sampled at edge t: state, `busy`, and the first actuator output are high from t+1.
- Candy-only latency: motor high at cycles t+1..t+P, `done` at t+P+1, IDLE at t+P+2, with P=`PULSE_CYCLES`.
- Candy + coin: motor at t+1..t+P, gate at t+P+1..t+2P, `done` at t+2P+1. Motor and gate are never high in the same cycle.
- `stock`/`empty` update at the edge ending the last VEND cycle, visible at t+P+1.
- Pulse counter width is $clog2(PULSE_CYCLES+1). It counts down, reloads on each state entry, and P=1 yields a single-cycle pulse.

## Structure
- Shared package `vending_pkg` holds:
  - state encoding localparams (IDLE/VEND/COIN/DONE, 2 bits);
  - default `PULSE_CYCLES` and `INV_INIT` constants, shared with the vending FSM.
- One sub-module, `rise_detect`: a registered previous value plus rise output, with async active-low reset. It is instanced twice, for `candy` and `money_ret`.
- The FSM, pulse counter and stock counter stay in the top module. All outputs are registered except `empty` and `busy`, which are decoded from registers.

## Test plan
- Reset, then `candy` rises at cycle 5 → `vend_motor` high cycles 6–9, `done` at 10, `stock` 10→9, `coin_gate` never high.
- `candy` and `money_ret` rise together → motor 4 cycles, then gate 4 cycles, one `done` pulse, `stock` −1.
- Load `INV_INIT`=1, vend twice → the second candy rise yields a gate-only pulse, `fault`=1, `empty`=1, `stock` stays 0. Then `refill` → `stock`=1, `fault`=0.
- `money_ret` rises during VEND of an earlier candy-only transaction → ignored. There is no gate pulse, and no retrigger after `done` while the level stays high.
- `rst_n` low at the second motor cycle → `vend_motor`=0 asynchronously, no `done`, `stock`=`INV_INIT` after release.
- `refill` asserted on the decrement cycle → `stock`=`INV_INIT` (refill wins). Also check `PULSE_CYCLES`=1 → single-cycle motor pulse.

Source files
------------

// File: rtl/vending_pkg.sv
// vending_pkg: state encoding and default timing/stock constants shared by the vending FSM and dispenser.
package vending_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VEND = 2'd1,
    COIN = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam int PULSE_CYCLES_DEF = 4;
  localparam int INV_INIT_DEF = 10;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered previous value and combinational rising-edge output.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else prev_q <= d;
  assign rise = d & ~prev_q;
endmodule

// File: rtl/candy_dispenser.sv
// candy_dispenser: turns vend/coin-return request rises into timed solenoid pulses and tracks stock.
module candy_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int INV_WIDTH = 4,
  parameter int INV_INIT = INV_INIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 candy,
  input  logic                 money_ret,
  input  logic                 refill,
  output logic                 vend_motor,
  output logic                 coin_gate,
  output logic                 busy,
  output logic                 done,
  output logic                 empty,
  output logic                 fault,
  output logic [INV_WIDTH-1:0] stock
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [INV_WIDTH-1:0] STOCK_INIT = INV_WIDTH'(INV_INIT);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [INV_WIDTH-1:0] stock_q, stock_d;
  logic pend_coin_q, pend_coin_d, fault_q, fault_d;
  logic vend_motor_q, vend_motor_d, coin_gate_q, coin_gate_d, done_q, done_d;
  logic candy_rise, coin_rise, last, dry;
  rise_detect u_candy (.clk(clk), .rst_n(rst_n), .d(candy), .rise(candy_rise));
  rise_detect u_coin (.clk(clk), .rst_n(rst_n), .d(money_ret), .rise(coin_rise));
  assign last = cnt_q == '0;
  assign dry = stock_q == '0;
  always_comb begin
    state_d = state_q;
    pend_coin_d = pend_coin_q;
    fault_d = fault_q;
    stock_d = stock_q;
    case (state_q)
      IDLE: if (candy_rise | coin_rise) begin
        // a vend request against an empty bin becomes a refund
        pend_coin_d = coin_rise | (candy_rise & dry);
        fault_d = fault_q | (candy_rise & dry);
        state_d = (candy_rise & ~dry) ? VEND : COIN;
      end
      VEND: if (last) begin
        stock_d = stock_q - 1'b1;
        state_d = pend_coin_q ? COIN : DONE;
      end
      COIN: state_d = last ? DONE : COIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (refill) begin
      stock_d = STOCK_INIT;
      fault_d = 1'b0;
    end
    cnt_d = (state_d != state_q) ? CNT_LOAD : last ? cnt_q : cnt_q - 1'b1;
    vend_motor_d = state_d == VEND;
    coin_gate_d = state_d == COIN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stock_q <= STOCK_INIT;
      pend_coin_q <= 1'b0;
      fault_q <= 1'b0;
      vend_motor_q <= 1'b0;
      coin_gate_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stock_q <= stock_d;
      pend_coin_q <= pend_coin_d;
      fault_q <= fault_d;
      vend_motor_q <= vend_motor_d;
      coin_gate_q <= coin_gate_d;
      done_q <= done_d;
    end
  assign vend_motor = vend_motor_q;
  assign coin_gate = coin_gate_q;
  assign done = done_q;
  assign fault = fault_q;
  assign stock = stock_q;
  assign empty = dry;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_candy_dispenser.sv
// tb_candy_dispenser: two dispensers (P=4/INIT=10 and P=1/INIT=1) on shared stimulus, transaction scoreboard.
module tb_candy_dispenser;
  logic clk = 0, rst_n = 0, candy = 0, money_ret = 0, refill = 0;
  logic [1:0] vm, cg, bz, dn, em, ft;
  logic [3:0] st[2];
  always #5 clk = ~clk;

  candy_dispenser u0 (
    .clk(clk), .rst_n(rst_n), .candy(candy), .money_ret(money_ret), .refill(refill),
    .vend_motor(vm[0]), .coin_gate(cg[0]), .busy(bz[0]), .done(dn[0]), .empty(em[0]),
    .fault(ft[0]), .stock(st[0])
  );
  candy_dispenser #(.PULSE_CYCLES(1), .INV_WIDTH(4), .INV_INIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .candy(candy), .money_ret(money_ret), .refill(refill),
    .vend_motor(vm[1]), .coin_gate(cg[1]), .busy(bz[1]), .done(dn[1]), .empty(em[1]),
    .fault(ft[1]), .stock(st[1])
  );

  typedef struct {int inst; int done_e; int mot; int gat;} exp_t;
  exp_t sbq[$];
  int cyc = 0, tests = 0, fails = 0;
  int stock_m[2], end_m[2], dec_m[2];
  bit fault_m[2];
  bit pc, pm, fin = 0, drained = 0;
  int mc[2], gc[2];
  bit bad_ord[2];

  function automatic int pl(int i);
    return i == 0 ? 4 : 1;
  endfunction
  function automatic int ini(int i);
    return i == 0 ? 10 : 1;
  endfunction

  // Transaction-level reference: decides what each captured request should produce.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc = 0;
      pm = 0;
      sbq.delete();
      for (int i = 0; i < 2; i++) begin
        stock_m[i] = ini(i);
        end_m[i] = -10;
        dec_m[i] = -1;
        fault_m[i] = 0;
      end
    end else begin
      bit cr, mr, vend, coin, cap;
      int so, len;
      cyc++;
      cr = candy & !pc;
      mr = money_ret & !pm;
      for (int i = 0; i < 2; i++) begin
        so = stock_m[i];
        cap = (cyc >= end_m[i] + 2) && (cr || mr);
        vend = cap && cr && so != 0;
        coin = cap && (mr || (cr && so == 0));
        if (cap && cr && so == 0) fault_m[i] = 1;
        if (cyc == dec_m[i]) stock_m[i] = so - 1;
        if (refill) begin
          stock_m[i] = ini(i);
          fault_m[i] = 0;
        end
        if (cap) begin
          len = (vend ? pl(i) : 0) + (coin ? pl(i) : 0);
          end_m[i] = cyc + len;
          dec_m[i] = vend ? cyc + pl(i) : -1;
          sbq.push_back('{i, cyc + len, vend ? pl(i) : 0, coin ? pl(i) : 0});
        end
      end
      pc = candy;
      pm = money_ret;
    end
  end

  task automatic chk(string n, int i, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s[%0d] cyc %0d: got %0d expected %0d", n, i, cyc, a, e);
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("rst_motor", i, vm[i], 0);
        chk("rst_gate", i, cg[i], 0);
        chk("rst_done", i, dn[i], 0);
        mc[i] = 0;
        gc[i] = 0;
        bad_ord[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk("stock", i, st[i], stock_m[i]);
        chk("fault", i, ft[i], fault_m[i]);
        chk("empty", i, em[i], stock_m[i] == 0);
        chk("busy", i, bz[i], cyc <= end_m[i]);
        chk("overlap", i, vm[i] & cg[i], 0);
        if (vm[i]) begin
          mc[i]++;
          if (gc[i] > 0) bad_ord[i] = 1;
        end
        if (cg[i]) gc[i]++;
        if (dn[i]) begin
          int k;
          k = -1;
          for (int j = 0; j < sbq.size(); j++)
            if (k < 0 && sbq[j].inst == i) k = j;
          if (k < 0) chk("done_unexpected", i, dn[i], 0);
          else begin
            chk("done_cycle", i, cyc, sbq[k].done_e);
            chk("motor_cycles", i, mc[i], sbq[k].mot);
            chk("gate_cycles", i, gc[i], sbq[k].gat);
            chk("vend_before_coin", i, bad_ord[i], 0);
            sbq.delete(k);
          end
          mc[i] = 0;
          gc[i] = 0;
          bad_ord[i] = 0;
        end
      end
      if (fin && !drained) begin
        chk("sb_drain", 0, sbq.size(), 0);
        drained = 1;
      end
    end
  end

  task automatic step(bit c, bit m, bit r);
    @(posedge clk);
    #2;
    candy = c;
    money_ret = m;
    refill = r;
  endtask

  initial begin
    bit c, m, r;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (3) step(0, 0, 0);
    repeat (9) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    repeat (13) step(1, 1, 0);
    repeat (3) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    repeat (10) step(1, 1, 0);
    repeat (3) step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    step(1, 0, 1);
    repeat (5) step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 0;
    candy = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (6) step(0, 0, 0);
    c = 0;
    m = 0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) c = ~c;
      if ($urandom_range(0, 7) == 0) m = ~m;
      r = $urandom_range(0, 149) == 0;
      step(c, m, r);
    end
    repeat (20) step(0, 0, 0);
    fin = 1;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
